hdmi_capture_ctrl: RTL and testbench
====================================

HDMI_CAPTURE_CTRL -- requirements
Module: hdmi_capture_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 64, active pixels per line.
REQ-002 SHALL have parameter V_RES, default 64, active lines per frame.
REQ-003 SHALL have port clk, input, 1, pixel clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_de, input, 1, video data enable.
REQ-006 SHALL have port in_hs, input, 1, hsync, active low.
REQ-007 SHALL have port in_vs, input, 1, vsync, active low.
REQ-008 SHALL have port in_rgb, input, 24, pixel {r,g,b}.
REQ-009 SHALL have port cap_req, input, 1, single-cycle request to capture one frame.
REQ-010 SHALL have port cap_abort, input, 1, single-cycle abort.
REQ-011 SHALL have port cap_busy, output, 1, high in ARM or CAPTURE.
REQ-012 SHALL have port cap_done, output, 1, one-cycle pulse on a good frame.
REQ-013 SHALL have port cap_err, output, 1, one-cycle pulse on a bad frame.
REQ-014 SHALL have port px_we, output, 1, pixel write strobe to the frame buffer.
REQ-015 SHALL have port px_x, output, 11, column of the written pixel.
REQ-016 SHALL have port px_y, output, 11, row of the written pixel.
REQ-017 SHALL have port px_data, output, 24, pixel written.
REQ-018 SHALL have port frame_cnt, output, 8, count of completed good captures.

Function
REQ-019 SHALL detect frame start (FS) as an in_vs 1->0 transition, using a registered copy of in_vs.
REQ-020 SHALL detect line end (LE) as an in_de 1->0 transition.
REQ-021 SHALL use FSM states IDLE, ARM, CAPTURE and CHECK.
REQ-022 SHALL, in IDLE on cap_req, go to ARM; SHALL ignore cap_req in every other state.
REQ-023 SHALL, in ARM on FS, clear x, y, line_err and bounds_err, then go to CAPTURE.
REQ-024 SHALL, in CAPTURE, increment x on each in_de cycle.
REQ-025 SHALL, on LE in CAPTURE, set line_err if x!=H_RES, clear x and increment y.
REQ-026 SHALL, in CAPTURE, assert px_we exactly one cycle after each in_de=1 sample with x<H_RES and y<V_RES.
REQ-027 SHALL drive px_x, px_y and px_data on the same cycle as px_we, holding the sampled x, y and in_rgb.
REQ-028 SHALL suppress px_we for any in_de=1 sample with x>=H_RES or y>=V_RES, and set bounds_err.
REQ-029 SHALL set bounds_err if in_de=1 while in_vs=0.
REQ-030 SHALL, on the next FS in CAPTURE, go to CHECK; that FS is not consumed as a new start.
REQ-031 SHALL, in CHECK (one cycle), pulse cap_done and increment frame_cnt if y==V_RES and no error flag is set; otherwise SHALL pulse cap_err; then go to IDLE.
REQ-032 SHALL let frame_cnt wrap from 255 to 0.
REQ-033 SHALL, on cap_abort in ARM or CAPTURE, go to IDLE the next cycle, with no cap_done, no cap_err and no further px_we.
REQ-034 SHALL let cap_abort win over cap_req when both arrive in the same cycle.
REQ-035 SHALL ignore in_hs functionally; it is an input for alignment only.
REQ-036 SHALL keep x and y saturating at 2047 so they never wrap.

Reset
REQ-037 SHALL, on rst, force state IDLE and set cap_busy, cap_done, cap_err, px_we, px_x, px_y, px_data and frame_cnt to 0.
REQ-038 SHALL, on rst mid-capture, take effect immediately, drop px_we with no cycle delay, and report no frame result.

Verification
REQ-039 SHALL cover a good frame: 64x64 active, h blanking 8/2/8, v blanking 8/4/8, cap_req in IDLE -> exactly 4096 px_we, px_x 0..63, px_y 0..63, then cap_done once, frame_cnt=1.
REQ-040 SHALL cover a short line: line 10 has 63 de cycles -> 4095 px_we, then cap_err, frame_cnt unchanged.
REQ-041 SHALL cover an abort: cap_abort at line 20 -> px_we stops, no cap_done or cap_err, cap_busy=0 next cycle; a following cap_req captures a good frame.
REQ-042 SHALL cover cap_req during CAPTURE -> ignored; exactly one cap_done.
REQ-043 SHALL cover reset mid-capture: rst at pixel (5,30) -> all outputs 0 asynchronously, state IDLE.
REQ-044 SHALL cover frame_cnt wrap: 256 good captures -> frame_cnt=0.

Source files
------------

// File: rtl/hdmi_capture_ctrl.sv
// hdmi_capture_ctrl
// Captures one video frame on request and streams it as pixel writes to a
// frame buffer. A frame starts on the falling edge of vsync; the next falling
// edge ends it and the frame is judged good or bad.
//
// Ports
//   clk        pixel clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   in_de      video data enable
//   in_hs      hsync (active low), not used by the logic
//   in_vs      vsync (active low)
//   in_rgb     pixel {r,g,b}
//   cap_req    single-cycle request to capture one frame
//   cap_abort  single-cycle abort, wins over cap_req
//   cap_busy   high while armed or capturing
//   cap_done   one-cycle pulse on a good frame
//   cap_err    one-cycle pulse on a bad frame
//   px_we      pixel write strobe
//   px_x/px_y  column/row of the written pixel
//   px_data    written pixel
//   frame_cnt  count of good captures, wraps at 256
//
// state   | meaning
// IDLE    | waiting for cap_req
// ARM     | request accepted, waiting for frame start
// CAPTURE | writing pixels, tracking line/bounds errors
// CHECK   | one cycle, report frame result
module hdmi_capture_ctrl #(
  parameter int H_RES = 64,
  parameter int V_RES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [23:0] in_rgb,
  input  logic        cap_req,
  input  logic        cap_abort,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        cap_err,
  output logic        px_we,
  output logic [10:0] px_x,
  output logic [10:0] px_y,
  output logic [23:0] px_data,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);
  localparam logic [10:0] C_MAX = 11'h7FF;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, CHECK} state_t;

  state_t      state_q, state_d;
  logic        vs_q, de_q;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        line_err_q, line_err_d;
  logic        bounds_err_q, bounds_err_d;
  logic        px_we_q, px_we_d;
  logic [10:0] px_x_q, px_x_d, px_y_q, px_y_d;
  logic [23:0] px_data_q, px_data_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        fs, le;
  logic        unused_hs;

  assign unused_hs = in_hs;

  assign fs = vs_q & ~in_vs;
  assign le = de_q & ~in_de;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vs_q         <= 1'b1;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      line_err_q   <= 1'b0;
      bounds_err_q <= 1'b0;
      px_we_q      <= 1'b0;
      px_x_q       <= '0;
      px_y_q       <= '0;
      px_data_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      vs_q         <= in_vs;
      de_q         <= in_de;
      x_q          <= x_d;
      y_q          <= y_d;
      line_err_q   <= line_err_d;
      bounds_err_q <= bounds_err_d;
      px_we_q      <= px_we_d;
      px_x_q       <= px_x_d;
      px_y_q       <= px_y_d;
      px_data_q    <= px_data_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_err_d   = line_err_q;
    bounds_err_d = bounds_err_q;
    px_we_d      = 1'b0;
    px_x_d       = px_x_q;
    px_y_d       = px_y_q;
    px_data_d    = px_data_q;
    frame_cnt_d  = frame_cnt_q;
    cap_done     = 1'b0;
    cap_err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cap_req && !cap_abort) state_d = ARM;
      end
      ARM: begin
        if (cap_abort) begin
          state_d = IDLE;
        end else if (fs) begin
          x_d          = '0;
          y_d          = '0;
          line_err_d   = 1'b0;
          bounds_err_d = 1'b0;
          state_d      = CAPTURE;
        end
      end
      CAPTURE: begin
        if (cap_abort) begin
          state_d = IDLE;
        end else if (fs) begin
          // The closing frame start only ends this capture; it does not re-arm.
          state_d = CHECK;
        end else begin
          if (in_de) begin
            if (x_q < H_LIM && y_q < V_LIM) begin
              px_we_d   = 1'b1;
              px_x_d    = x_q;
              px_y_d    = y_q;
              px_data_d = in_rgb;
            end else begin
              bounds_err_d = 1'b1;
            end
            if (!in_vs) bounds_err_d = 1'b1;
            if (x_q != C_MAX) x_d = x_q + 11'd1;
          end
          if (le) begin
            if (x_q != H_LIM) line_err_d = 1'b1;
            x_d = '0;
            if (y_q != C_MAX) y_d = y_q + 11'd1;
          end
        end
      end
      CHECK: begin
        if (y_q == V_LIM && !line_err_q && !bounds_err_q) begin
          cap_done    = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          cap_err = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cap_busy  = (state_q == ARM) || (state_q == CAPTURE);
  assign px_we     = px_we_q;
  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign px_data   = px_data_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_capture_ctrl.sv
module tb_hdmi_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_de = 1'b0, in_hs = 1'b1, in_vs = 1'b1;
  logic [23:0] in_rgb = '0;
  logic        cap_req = 1'b0, cap_abort = 1'b0;
  logic        cap_busy, cap_done, cap_err, px_we;
  logic [10:0] px_x, px_y;
  logic [23:0] px_data;
  logic [7:0]  frame_cnt;

  // small instance used for the frame counter wrap
  logic        s_de = 1'b0, s_hs = 1'b1, s_vs = 1'b1, s_req = 1'b0, s_abort = 1'b0;
  logic [23:0] s_rgb = '0;
  logic        s_busy, s_done, s_err, s_we;
  logic [10:0] s_x, s_y;
  logic [23:0] s_data;
  logic [7:0]  s_frame_cnt;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0;
  int s_we_cnt = 0, s_done_cnt = 0, s_err_cnt = 0;
  int exp_fc = 0;

  logic [45:0] sb[$];
  logic [45:0] mon_exp;
  bit          push_en = 1'b0;

  int h_short = -1, h_abort_l = -1, h_abort_x = -1, h_rst_l = -1, h_rst_x = -1, h_req_l = -1;

  always #5 clk = ~clk;

  hdmi_capture_ctrl #(.H_RES(64), .V_RES(64)) dut (
    .clk(clk), .rst(rst), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_rgb(in_rgb),
    .cap_req(cap_req), .cap_abort(cap_abort), .cap_busy(cap_busy), .cap_done(cap_done),
    .cap_err(cap_err), .px_we(px_we), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .frame_cnt(frame_cnt)
  );

  hdmi_capture_ctrl #(.H_RES(4), .V_RES(2)) dut_s (
    .clk(clk), .rst(rst), .in_de(s_de), .in_hs(s_hs), .in_vs(s_vs), .in_rgb(s_rgb),
    .cap_req(s_req), .cap_abort(s_abort), .cap_busy(s_busy), .cap_done(s_done),
    .cap_err(s_err), .px_we(s_we), .px_x(s_x), .px_y(s_y), .px_data(s_data),
    .frame_cnt(s_frame_cnt)
  );

  // scoreboard monitor: every write must match the oldest expected pixel
  always @(posedge clk) begin
    #1;
    if (px_we === 1'b1) begin
      we_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL px_unexpected: write at x=%0d y=%0d data=%h, required no write", px_x, px_y, px_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({px_x, px_y, px_data} !== mon_exp) begin
          errors++;
          $display("FAIL px_content: got x=%0d y=%0d data=%h, required x=%0d y=%0d data=%h",
                   px_x, px_y, px_data, mon_exp[45:35], mon_exp[34:24], mon_exp[23:0]);
        end
      end
    end
    if (cap_done === 1'b1) done_cnt++;
    if (cap_err === 1'b1) err_cnt++;
    if (s_we === 1'b1) s_we_cnt++;
    if (s_done === 1'b1) s_done_cnt++;
    if (s_err === 1'b1) s_err_cnt++;
  end

  task automatic drive(input bit de, input bit vs, input bit hs, input logic [23:0] rgb,
                       input bit req, input bit abt, input bit r);
    @(negedge clk);
    in_de = de; in_vs = vs; in_hs = hs; in_rgb = rgb;
    cap_req = req; cap_abort = abt; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 1, '0, 0, 0, 0);
  endtask

  task automatic request();
    drive(0, 1, 1, '0, 1, 0, 0);
    @(posedge clk); #1;
    checks++;
    if (cap_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_req: got %b, required 1", cap_busy);
    end
  endtask

  task automatic send_line(input bit vs, input int l, input int n);
    logic [23:0] rgb;
    bit abort_now, rst_now, req_now;
    for (int i = 0; i < 8; i++) drive(0, vs, 1, '0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive(0, vs, 0, '0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, vs, 1, '0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      rgb       = 24'($urandom);
      abort_now = (l == h_abort_l) && (i == h_abort_x);
      rst_now   = (l == h_rst_l) && (i == h_rst_x);
      req_now   = (l == h_req_l) && (i == 0);
      if (abort_now || rst_now) push_en = 1'b0;
      if (push_en) sb.push_back({11'(i), 11'(l), rgb});
      drive(1, 1, 1, rgb, req_now, abort_now, rst_now);
      if (rst_now) begin
        #1;
        sb.delete();
        checks++;
        if ({cap_busy, cap_done, cap_err, px_we} !== 4'b0000) begin
          errors++;
          $display("FAIL rst_ctrl_outs: got busy/done/err/we=%b, required 0000",
                   {cap_busy, cap_done, cap_err, px_we});
        end
        checks++;
        if ({px_x, px_y, px_data, frame_cnt} !== '0) begin
          errors++;
          $display("FAIL rst_data_outs: got x=%0d y=%0d data=%h cnt=%0d, required all 0",
                   px_x, px_y, px_data, frame_cnt);
        end
      end
      if (abort_now) begin
        @(posedge clk); #1;
        checks++;
        if (cap_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_abort: got %b, required 0", cap_busy);
        end
      end
    end
  endtask

  task automatic send_frame(input int short_l, input int abort_l, input int abort_x,
                            input int rst_l, input int rst_x, input int req_l);
    h_short = short_l; h_abort_l = abort_l; h_abort_x = abort_x;
    h_rst_l = rst_l; h_rst_x = rst_x; h_req_l = req_l;
    for (int v = 0; v < 4; v++) send_line(0, -1, 0);
    for (int v = 0; v < 8; v++) send_line(1, -1, 0);
    for (int l = 0; l < 64; l++) send_line(1, l, (l == short_l) ? 63 : 64);
    for (int v = 0; v < 8; v++) send_line(1, -1, 0);
    // closing vsync ends the capture
    for (int i = 0; i < 3; i++) drive(0, 0, 1, '0, 0, 0, 0);
    idle(6);
  endtask

  task automatic check_frame(input string tag, input int we0, input int d0, input int e0,
                             input int exp_we, input int exp_d, input int exp_e);
    checks++;
    if (we_cnt - we0 !== exp_we) begin
      errors++;
      $display("FAIL %s_we_count: got %0d, required %0d", tag, we_cnt - we0, exp_we);
    end
    checks++;
    if (done_cnt - d0 !== exp_d) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, required %0d", tag, done_cnt - d0, exp_d);
    end
    checks++;
    if (err_cnt - e0 !== exp_e) begin
      errors++;
      $display("FAIL %s_err_count: got %0d, required %0d", tag, err_cnt - e0, exp_e);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d pending, required 0", tag, sb.size());
    end
    checks++;
    if (frame_cnt !== 8'(exp_fc)) begin
      errors++;
      $display("FAIL %s_frame_cnt: got %0d, required %0d", tag, frame_cnt, exp_fc);
    end
    checks++;
    if (cap_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end: got %b, required 0", tag, cap_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cap_busy, cap_done, cap_err, px_we, px_x, px_y, px_data, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b we=%b x=%0d y=%0d data=%h cnt=%0d, required all 0",
               cap_busy, cap_done, cap_err, px_we, px_x, px_y, px_data, frame_cnt);
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_good_frame();
    int we0 = we_cnt, d0 = done_cnt, e0 = err_cnt;
    idle(4);
    push_en = 1'b1;
    request();
    send_frame(-1, -1, -1, -1, -1, -1);
    push_en = 1'b0;
    exp_fc++;
    check_frame("good", we0, d0, e0, 4096, 1, 0);
  endtask

  task automatic test_short_line();
    int we0 = we_cnt, d0 = done_cnt, e0 = err_cnt;
    idle(4);
    push_en = 1'b1;
    request();
    send_frame(10, -1, -1, -1, -1, -1);
    push_en = 1'b0;
    check_frame("short", we0, d0, e0, 4095, 0, 1);
  endtask

  task automatic test_abort();
    int we0 = we_cnt, d0 = done_cnt, e0 = err_cnt;
    idle(4);
    push_en = 1'b1;
    request();
    send_frame(-1, 20, 10, -1, -1, -1);
    push_en = 1'b0;
    check_frame("abort", we0, d0, e0, 20 * 64 + 10, 0, 0);
    test_good_frame();
  endtask

  task automatic test_req_in_capture();
    int we0 = we_cnt, d0 = done_cnt, e0 = err_cnt;
    idle(4);
    push_en = 1'b1;
    request();
    send_frame(-1, -1, -1, -1, -1, 32);
    push_en = 1'b0;
    exp_fc++;
    check_frame("req_mid", we0, d0, e0, 4096, 1, 0);
  endtask

  task automatic test_reset_mid();
    int we0 = we_cnt, d0 = done_cnt, e0 = err_cnt;
    idle(4);
    push_en = 1'b1;
    request();
    send_frame(-1, -1, -1, 30, 5, -1);
    push_en = 1'b0;
    exp_fc = 0;
    check_frame("rst_mid", we0, d0, e0, 30 * 64 + 5, 0, 0);
  endtask

  task automatic s_drive(input bit de, input bit vs, input bit req);
    @(negedge clk);
    s_de = de; s_vs = vs; s_req = req; s_rgb = 24'($urandom);
  endtask

  task automatic s_line(input bit vs, input int n);
    for (int i = 0; i < 2; i++) s_drive(0, vs, 0);
    for (int i = 0; i < n; i++) s_drive(1, vs, 0);
  endtask

  task automatic test_frame_cnt_wrap();
    int d0 = s_done_cnt, e0 = s_err_cnt, w0 = s_we_cnt;
    for (int f = 0; f < 256; f++) begin
      s_drive(0, 1, 1);
      s_line(0, 0);
      s_line(1, 0);
      s_line(1, 4);
      s_line(1, 4);
      s_line(1, 0);
      s_drive(0, 0, 0);
      s_drive(0, 0, 0);
      for (int i = 0; i < 3; i++) s_drive(0, 1, 0);
      if (f == 0 || f == 254) begin
        checks++;
        if (s_frame_cnt !== 8'(f + 1)) begin
          errors++;
          $display("FAIL wrap_cnt_frame%0d: got %0d, required %0d", f, s_frame_cnt, f + 1);
        end
      end
    end
    checks++;
    if (s_frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_cnt_final: got %0d, required 0", s_frame_cnt);
    end
    checks++;
    if (s_done_cnt - d0 !== 256 || s_err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL wrap_results: got done=%0d err=%0d, required done=256 err=0",
               s_done_cnt - d0, s_err_cnt - e0);
    end
    checks++;
    if (s_we_cnt - w0 !== 256 * 8) begin
      errors++;
      $display("FAIL wrap_writes: got %0d, required %0d", s_we_cnt - w0, 256 * 8);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_line();
    test_abort();
    test_req_in_capture();
    test_reset_mid();
    test_frame_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
